gray_to_rgb565_ci: RTL and testbench
====================================

Name: gray_to_rgb565_ci

Overview:
Custom-instruction block for the inverse of the RGB565-to-grayscale path: it expands 8-bit grayscale samples back into RGB565 pixels for the display/framebuffer side. Software pushes packed gray bytes into an 8-entry sample FIFO (LOAD). It then pops two samples per READ and gets two RGB565 pixels packed in one 32-bit result. The block sits on the CPU custom-instruction bus (start/ciN/valueA/valueB/done/result); its result is ORed onto that bus.

Parameters:
customInstructionId, 8'h00, ciN value this block responds to

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
start  input  1  custom-instruction start strobe, one cycle
ciN  input  8  custom-instruction number; block acts only when equal to customInstructionId
valueA  input  32  LOAD data: four gray bytes
valueB  input  32  opcode in [1:0]; bits [31:2] ignored
done  output  1  one-cycle completion pulse
result  output  32  instruction result; 32'd0 whenever done=0

Behaviour:
- Accepted instruction: start=1 and ciN==customInstructionId and block idle (no READ in flight). Any other start is ignored with no state change and no done.
- Opcodes (valueB[1:0]):
  - 0 LOAD: push valueA[7:0], [15:8], [23:16], [31:24] in that order.
  - 1 READ: pop two samples.
  - 2 STATUS: no state change.
  - 3 CLEAR: empty the FIFO.
- FIFO state: 8 x 8-bit storage, 3-bit write/read pointers wrapping 7->0, 4-bit count 0..8.
- LOAD/STATUS/CLEAR latency: state update on the accept edge; done=1 for exactly the following cycle.
  - result[3:0] = count after the op; result[4] = error; other bits 0.
- LOAD with count>4: error=1, nothing written, count unchanged (no partial push).
- CLEAR: pointers=0, count=0, result=0. Any pending READ data is discarded.
- READ latency is 2 cycles.
  - Accept edge: the two oldest samples are registered and count decreases by 2.
  - Next edge: conversion is registered.
  - done=1 during the second cycle after accept.
  - The block is busy from the accept edge until done falls; start during busy is ignored.
- READ with count<2: no pop, count unchanged, same 2-cycle latency, result=32'd0.
- Conversion for gray g[7:0]: pixel = {g[7:3], g[7:2], g[7:3]}, i.e. R5 G6 B5.
- READ result: [15:0] = pixel of the oldest sample, [31:16] = pixel of the second sample.
- done is never high for two consecutive cycles. Back-to-back accepted instructions are allowed (a new start may coincide with the previous done cycle).
- Reset (reset=0), at any time including mid-READ:
  - done=0, result=0, pointers=0, count=0, pipeline and busy cleared.
  - An aborted READ produces no done after reset release.
  - FIFO storage contents are don't-care.

Test Plan:
1. Reset: hold reset=0 with start=1 on a matching ciN -> done=0, result=0. After release, STATUS -> result=0x00000000, done exactly 1 cycle after accept.
2. LOAD valueA=0x80FF0800 -> result=0x4. READ -> done 2 cycles after accept, result=0x08410000 (g=0x00->0x0000, g=0x08->0x0841). Second READ -> result=0x8410FFFF (0xFF->0xFFFF, 0x80->0x8410). Then STATUS -> 0x0.
3. Overflow: two LOADs -> count 8, result 0x8. A third LOAD -> result=0x18, count stays 8. Four READs return the first eight bytes in push order.
4. Underflow: READ with count 0 or 1 -> result=0x00000000 after 2 cycles, count unchanged. Then LOAD, then STATUS -> count = previous count + 4.
5. Wrap-around: LOAD A; READ x2; LOAD B; LOAD C -> count 8, pointers wrapped. Four READs return the bytes of B then C in order, with correct RGB565 packing.
6. Filtering and abort:
   - start with ciN=0x01 -> no done, state unchanged.
   - start during a busy READ -> ignored.
   - reset pulsed 1 cycle after READ accept -> no done; STATUS after release -> 0x0.

Source files
------------

// File: rtl/gray_to_rgb565_ci_if.sv
// Custom-instruction bus bundle shared by the CPU (master) and the
// grayscale-to-RGB565 expander (slave).
interface gray_to_rgb565_ci_if;
    logic        start;
    logic [7:0]  ciN;
    logic [31:0] valueA;
    logic [31:0] valueB;
    logic        done;
    logic [31:0] result;

    modport master (
        output start,
        output ciN,
        output valueA,
        output valueB,
        input  done,
        input  result
    );

    modport slave (
        input  start,
        input  ciN,
        input  valueA,
        input  valueB,
        output done,
        output result
    );
endinterface

// File: rtl/gray_to_rgb565_ci.sv
// Grayscale-to-RGB565 custom instruction.
// Software LOADs packed gray bytes into an 8-deep sample FIFO, then each
// READ pops two samples and returns two RGB565 pixels in one 32-bit word.
// LOAD/STATUS/CLEAR answer one cycle after accept; READ answers after two.
module gray_to_rgb565_ci #(
    parameter logic [7:0] customInstructionId = 8'h00
) (
    input  logic                 clock,
    input  logic                 reset,
    gray_to_rgb565_ci_if.slave   bus
);

    typedef enum logic [1:0] {
        OP_LOAD   = 2'd0,
        OP_READ   = 2'd1,
        OP_STATUS = 2'd2,
        OP_CLEAR  = 2'd3
    } op_e;

    // ST_CONV is the single busy cycle between READ accept and its done cycle.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_CONV = 1'b1
    } state_e;

    // Expand one gray sample to R5 G6 B5 by replicating its top bits.
    function automatic logic [15:0] to_rgb565(input logic [7:0] g);
        return {g[7:3], g[7:2], g[7:3]};
    endfunction

    // Sample storage and FIFO bookkeeping.
    logic [7:0]  mem [8];
    logic [2:0]  wr_ptr;
    logic [2:0]  rd_ptr;
    logic [3:0]  count;

    // Instruction decode.
    state_e      state;
    state_e      state_next;
    logic        accept;
    op_e         op;
    logic        load_ok;
    logic        pop_ok;
    logic        err;
    logic [3:0]  count_after;

    // READ pipeline: the two popped samples and whether the pop happened.
    logic [7:0]  s0;
    logic [7:0]  s1;
    logic        rd_ok;

    // Registered response.
    logic        done_q;
    logic [31:0] result_q;

    // Precomputed wrapped pointer offsets.
    logic [2:0]  wr_p1;
    logic [2:0]  wr_p2;
    logic [2:0]  wr_p3;
    logic [2:0]  rd_p1;

    // Only the opcode bits of valueB carry meaning.
    logic        unused_opcode_bits;

    assign op      = op_e'(bus.valueB[1:0]);
    assign load_ok = (count <= 4'd4);
    assign pop_ok  = (count >= 4'd2);
    assign wr_p1   = wr_ptr + 3'd1;
    assign wr_p2   = wr_ptr + 3'd2;
    assign wr_p3   = wr_ptr + 3'd3;
    assign rd_p1   = rd_ptr + 3'd1;

    assign unused_opcode_bits = ^bus.valueB[31:2];

    // The bus is ORed with other blocks, so result must be zero outside done.
    assign bus.done   = done_q;
    assign bus.result = done_q ? result_q : 32'd0;

    // Control FSM state register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            // NOTE: every clocked assignment is non-blocking so all registers
            // see the pre-edge values of their inputs, independent of order.
            state <= state_next;
        end
    end

    // Next-state and accept decode; starts are filtered while a READ is busy.
    always_comb begin
        // NOTE: defaults first so no path leaves an output unassigned,
        // which would otherwise infer a latch.
        state_next = state;
        accept     = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (bus.start && (bus.ciN == customInstructionId)) begin
                    accept = 1'b1;
                    if (op == OP_READ) begin
                        state_next = ST_CONV;
                    end
                end
            end
            ST_CONV: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Status word contents: the count the op leaves behind and the error flag.
    always_comb begin
        count_after = count;
        err         = 1'b0;
        unique case (op)
            OP_LOAD: begin
                if (load_ok) begin
                    count_after = count + 4'd4;
                end else begin
                    err = 1'b1;
                end
            end
            OP_CLEAR:  count_after = 4'd0;
            OP_READ:   count_after = count;
            OP_STATUS: count_after = count;
            default:   count_after = count;
        endcase
    end

    // Sample storage writes; a LOAD is all-or-nothing.
    always_ff @(posedge clock) begin
        // NOTE: the sample array is deliberately left out of reset; its
        // contents are unreachable until rewritten, and skipping reset lets
        // it map onto plain storage.
        if (accept && (op == OP_LOAD) && load_ok) begin
            mem[wr_ptr] <= bus.valueA[7:0];
            mem[wr_p1]  <= bus.valueA[15:8];
            mem[wr_p2]  <= bus.valueA[23:16];
            mem[wr_p3]  <= bus.valueA[31:24];
        end
    end

    // FIFO pointers, READ pipeline and response register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr   <= 3'd0;
            rd_ptr   <= 3'd0;
            count    <= 4'd0;
            s0       <= 8'd0;
            s1       <= 8'd0;
            rd_ok    <= 1'b0;
            done_q   <= 1'b0;
            result_q <= 32'd0;
        end else begin
            done_q <= 1'b0;

            if (accept) begin
                unique case (op)
                    OP_LOAD: begin
                        if (load_ok) begin
                            wr_ptr <= wr_ptr + 3'd4;
                            count  <= count + 4'd4;
                        end
                        done_q   <= 1'b1;
                        result_q <= {27'd0, err, count_after};
                    end
                    OP_READ: begin
                        // Samples are captured even on underflow; rd_ok
                        // masks them out of the result.
                        s0    <= mem[rd_ptr];
                        s1    <= mem[rd_p1];
                        rd_ok <= pop_ok;
                        if (pop_ok) begin
                            rd_ptr <= rd_ptr + 3'd2;
                            count  <= count - 4'd2;
                        end
                    end
                    OP_STATUS: begin
                        done_q   <= 1'b1;
                        result_q <= {27'd0, err, count_after};
                    end
                    OP_CLEAR: begin
                        wr_ptr   <= 3'd0;
                        rd_ptr   <= 3'd0;
                        count    <= 4'd0;
                        rd_ok    <= 1'b0;
                        done_q   <= 1'b1;
                        result_q <= 32'd0;
                    end
                    default: begin
                        done_q <= 1'b0;
                    end
                endcase
            end

            // Second READ stage: convert the captured pair and answer.
            if (state == ST_CONV) begin
                done_q   <= 1'b1;
                result_q <= rd_ok ? {to_rgb565(s1), to_rgb565(s0)} : 32'd0;
            end
        end
    end

endmodule

// File: tb/tb_gray_to_rgb565_ci.sv
// Directed bench for gray_to_rgb565_ci: a table of sequential instructions
// with hand-computed results and latencies, plus hand-written sequences for
// reset, ciN filtering, busy filtering and READ abort by reset.
module tb_gray_to_rgb565_ci;

    localparam logic [7:0] CI_ID = 8'h00;
    localparam logic [1:0] OP_LOAD   = 2'd0;
    localparam logic [1:0] OP_READ   = 2'd1;
    localparam logic [1:0] OP_STATUS = 2'd2;
    localparam logic [1:0] OP_CLEAR  = 2'd3;
    localparam int         NVEC = 30;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] exp_res;
        int          exp_lat;
    } vec_t;

    logic clock;
    logic reset;
    int   n_checks;
    int   n_fail;
    vec_t vecs [NVEC];

    gray_to_rgb565_ci_if bus ();

    gray_to_rgb565_ci #(.customInstructionId(CI_ID)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Issue one instruction at a negedge, then watch up to 6 cycles for done.
    // Returns at the negedge after the done cycle (or after the budget).
    task automatic run_ci(input logic [7:0] ci, input logic [1:0] op, input logic [31:0] a,
                          output logic [31:0] res, output int lat);
        bus.start  = 1'b1;
        bus.ciN    = ci;
        bus.valueA = a;
        bus.valueB = {30'h2AAAAAAA, op};
        @(posedge clock);
        #1;
        bus.start  = 1'b0;
        bus.valueA = 32'hDEADBEEF;
        res = 32'd0;
        lat = 0;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clock);
            if (bus.done === 1'b1) begin
                res = bus.result;
                lat = i;
                break;
            end
        end
        if (lat != 0) @(negedge clock);
    endtask

    // Full instruction with result, latency and one-cycle done checks.
    task automatic do_ci(input string name, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] exp_res, input int exp_lat);
        logic [31:0] res;
        int          lat;
        run_ci(CI_ID, op, a, res, lat);
        check({name, "_lat"}, 32'(lat), 32'(exp_lat));
        check({name, "_res"}, res, exp_res);
        check({name, "_done_width"}, {31'd0, bus.done}, 32'd0);
    endtask

    initial begin
        logic [31:0] res;
        int          lat;
        n_checks = 0;
        n_fail   = 0;

        // Sequential vectors: {op, valueA, result, latency}.
        vecs[0]  = '{OP_STATUS, 32'h0,        32'h00000000, 1};
        vecs[1]  = '{OP_LOAD,   32'h80FF0800, 32'h00000004, 1};
        vecs[2]  = '{OP_READ,   32'h0,        32'h08410000, 2};
        vecs[3]  = '{OP_READ,   32'h0,        32'h8410FFFF, 2};
        vecs[4]  = '{OP_STATUS, 32'h0,        32'h00000000, 1};
        vecs[5]  = '{OP_LOAD,   32'h33221100, 32'h00000004, 1};
        vecs[6]  = '{OP_LOAD,   32'h77665544, 32'h00000008, 1};
        vecs[7]  = '{OP_LOAD,   32'hAABBCCDD, 32'h00000018, 1};
        vecs[8]  = '{OP_READ,   32'h0,        32'h10820000, 2};
        vecs[9]  = '{OP_READ,   32'h0,        32'h31862104, 2};
        vecs[10] = '{OP_READ,   32'h0,        32'h52AA4228, 2};
        vecs[11] = '{OP_READ,   32'h0,        32'h73AE632C, 2};
        vecs[12] = '{OP_READ,   32'h0,        32'h00000000, 2};
        vecs[13] = '{OP_STATUS, 32'h0,        32'h00000000, 1};
        vecs[14] = '{OP_LOAD,   32'h123456F8, 32'h00000004, 1};
        vecs[15] = '{OP_STATUS, 32'h0,        32'h00000004, 1};
        vecs[16] = '{OP_READ,   32'h0,        32'h52AAFFDF, 2};
        vecs[17] = '{OP_READ,   32'h0,        32'h108231A6, 2};
        vecs[18] = '{OP_LOAD,   32'h9F8F7F6F, 32'h00000004, 1};
        vecs[19] = '{OP_READ,   32'h0,        32'h7BEF6B6D, 2};
        vecs[20] = '{OP_READ,   32'h0,        32'h9CF38C71, 2};
        vecs[21] = '{OP_LOAD,   32'h40302010, 32'h00000004, 1};
        vecs[22] = '{OP_LOAD,   32'hF0E0D0C0, 32'h00000008, 1};
        vecs[23] = '{OP_READ,   32'h0,        32'h21041082, 2};
        vecs[24] = '{OP_READ,   32'h0,        32'h42083186, 2};
        vecs[25] = '{OP_READ,   32'h0,        32'hD69AC618, 2};
        vecs[26] = '{OP_READ,   32'h0,        32'hF79EE71C, 2};
        vecs[27] = '{OP_STATUS, 32'h0,        32'h00000000, 1};
        vecs[28] = '{OP_LOAD,   32'h11111111, 32'h00000004, 1};
        vecs[29] = '{OP_CLEAR,  32'h0,        32'h00000000, 1};

        // Reset held with a matching start strobe: nothing may answer.
        reset      = 1'b0;
        bus.start  = 1'b1;
        bus.ciN    = CI_ID;
        bus.valueA = 32'h04030201;
        bus.valueB = {30'd0, OP_LOAD};
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check("reset_done", {31'd0, bus.done}, 32'd0);
            check("reset_result", bus.result, 32'd0);
        end
        bus.start = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);

        for (int i = 0; i < NVEC; i++) begin
            do_ci($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].exp_res, vecs[i].exp_lat);
        end

        // Non-matching ciN: no done, and the FIFO stays empty.
        run_ci(8'h01, OP_LOAD, 32'h44332211, res, lat);
        check("filter_no_done", 32'(lat), 32'd0);
        do_ci("filter_status", OP_STATUS, 32'h0, 32'h00000000, 1);

        // Start during a busy READ: the CLEAR must be ignored.
        do_ci("busy_load", OP_LOAD, 32'h80FF0800, 32'h00000004, 1);
        bus.start  = 1'b1;
        bus.ciN    = CI_ID;
        bus.valueB = {30'd0, OP_READ};
        @(posedge clock);
        #1;
        bus.valueB = {30'd0, OP_CLEAR};
        @(negedge clock);
        check("busy_no_early_done", {31'd0, bus.done}, 32'd0);
        @(posedge clock);
        #1;
        bus.start = 1'b0;
        @(negedge clock);
        check("busy_read_done", {31'd0, bus.done}, 32'd1);
        check("busy_read_res", bus.result, 32'h08410000);
        @(negedge clock);
        check("busy_no_extra_done", {31'd0, bus.done}, 32'd0);
        do_ci("busy_status", OP_STATUS, 32'h0, 32'h00000002, 1);

        // Reset pulsed one cycle after READ accept: no done afterwards.
        bus.start  = 1'b1;
        bus.ciN    = CI_ID;
        bus.valueB = {30'd0, OP_READ};
        @(posedge clock);
        #1;
        bus.start = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        #1;
        check("abort_done_in_reset", {31'd0, bus.done}, 32'd0);
        @(negedge clock);
        reset = 1'b1;
        lat = 0;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clock);
            if (bus.done === 1'b1 && lat == 0) lat = i;
        end
        check("abort_no_done", 32'(lat), 32'd0);
        do_ci("abort_status", OP_STATUS, 32'h0, 32'h00000000, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
